fsm_responder: RTL and testbench
================================

Name: fsm_responder

Overview:
- Responder end of the start/done control handshake.
- The controller FSM issues a one-cycle `start` and waits for `done`; this block is what it talks to.
- On `start` it latches two unsigned operands and computes their product with a sequential shift-add multiplier, one bit per cycle.
- It then pulses `done` for one cycle with the result and exposes its own state encoding for observation.

Parameters:
- WIDTH, 8, operand width in bits. Must be >= 2. The result is 2*WIDTH bits.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset. reset=0 clears all state immediately, independent of clock.
- start  input  1  job request; sampled on the rising edge.
- a  input  WIDTH  multiplicand; sampled with `start`.
- b  input  WIDTH  multiplier; sampled with `start`.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse; high only in DONE.
- result  output  2*WIDTH  product of the last completed job.
- state  output  8  current state, zero-extended: IDLE=0, RUN=1, DONE=2.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE(0), busy=0, done=0, result=0.
  - Internal registers cleared: accumulator, shifted multiplicand (2*WIDTH), multiplier shift register (WIDTH), iteration counter (clog2(WIDTH) bits).
  - Reset release is synchronous to the next rising edge; the first edge with reset=1 is a normal cycle.
- All outputs are registered or decoded directly from the state register. No combinational path from inputs to outputs.
- IDLE:
  - start=1 at edge E0: load mcand={WIDTH zeros,a}, mplier=b, acc=0, count=0; go to RUN.
  - start=0: stay in IDLE.
- RUN (edges E1..EWIDTH):
  - Each edge: if mplier[0]=1 then acc<=acc+mcand. Then mcand<=mcand<<1, mplier<=mplier>>1, count<=count+1.
  - Addition is modulo 2^(2*WIDTH). It cannot overflow for in-range operands.
  - At the edge where count==WIDTH-1: go to DONE and load result with the final accumulated value, including that edge's add.
  - start is ignored in RUN; operands are not re-sampled.
- DONE (exactly one cycle, after edge EWIDTH):
  - done=1, busy=0, result valid.
  - Next edge with start=0: go to IDLE.
  - Next edge with start=1: accept a new job (same load as in IDLE) and go directly to RUN. Back-to-back jobs have no idle gap.
- Latency:
  - With start sampled at E0, done is high in the cycle following EWIDTH, i.e. WIDTH cycles after the start edge.
  - busy is high for exactly WIDTH cycles per job.
- result holds its value until the next job completes. It is not cleared on start.
- Reset mid-operation: the job is abandoned, no done pulse is generated, and result returns to 0.
- Boundary cases:
  - a=0 or b=0 gives result=0 after full latency; there is no early termination.
  - Maximum operands give result=(2^WIDTH-1)^2.
  - The state encodings 3..255 are never produced. If the state register ever holds an illegal value, the next edge returns it to IDLE.

Test Plan:
1. Hold reset=0 for 16 cycles, then release. Required: state=0, busy=0, done=0, result=0 throughout reset and on the first cycle after release.
2. a=3, b=5, start for one cycle. Required: state=1 and busy=1 for exactly 8 cycles; then state=2 with done=1 and result=15 for one cycle; then state=0 and done=0, with result still 15.
3. a=255, b=255, start. Required: done pulses 8 cycles after the start edge with result=65025 (0xFE01).
4. Start job a=4, b=4; during RUN assert start with a=9, b=9 for 3 cycles. Required: RUN is not extended, a single done pulse occurs, and result=16.
5. Job a=2, b=3; assert start with a=7, b=6 during its DONE cycle. Required: done=1 with result=6, then state=1 on the next cycle with no IDLE gap; second done after 8 cycles with result=42.
6. Start a=10, b=10; pull reset low after 4 RUN cycles. Required: state=0, busy=0, result=0 immediately, and no done pulse ever. After release, a=0, b=200 gives result=0 with full 8-cycle latency.

Source files
------------

// File: rtl/fsm_responder.sv
// Responder side of the start/done handshake: latches two operands on start,
// multiplies them with a one-bit-per-cycle shift-add loop, then pulses done.
module fsm_responder #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [7:0]           state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   acc_s;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [2*WIDTH-1:0]   mcand_s;
    logic [2*WIDTH-1:0]   result_r;
    logic [2*WIDTH-1:0]   result_s;
    logic [2*WIDTH-1:0]   sum_s;
    logic [WIDTH-1:0]     mplier_r;
    logic [WIDTH-1:0]     mplier_s;
    logic [CW-1:0]        count_r;
    logic [CW-1:0]        count_s;

    // Next-state and datapath update for the shift-add loop.
    always_comb begin
        state_s  = state_r;
        acc_s    = acc_r;
        mcand_s  = mcand_r;
        mplier_s = mplier_r;
        count_s  = count_r;
        result_s = result_r;

        if (mplier_r[0]) begin
            sum_s = acc_r + mcand_r;
        end else begin
            sum_s = acc_r;
        end

        case (state_r)
            IDLE, DONE: begin
                // DONE accepts a new job directly so back-to-back jobs have no gap
                if (start) begin
                    mcand_s  = {{WIDTH{1'b0}}, a};
                    mplier_s = b;
                    acc_s    = '0;
                    count_s  = '0;
                    state_s  = RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                acc_s    = sum_s;
                mcand_s  = {mcand_r[2*WIDTH-2:0], 1'b0};
                mplier_s = {1'b0, mplier_r[WIDTH-1:1]};
                count_s  = count_r + CW'(1);
                if (count_r == LAST_COUNT) begin
                    result_s = sum_s;
                    state_s  = DONE;
                end else begin
                    state_s  = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            count_r  <= '0;
            result_r <= '0;
        end else begin
            state_r  <= state_s;
            acc_r    <= acc_s;
            mcand_r  <= mcand_s;
            mplier_r <= mplier_s;
            count_r  <= count_s;
            result_r <= result_s;
        end
    end

    assign busy   = (state_r == RUN);
    assign done   = (state_r == DONE);
    assign result = result_r;
    assign state  = {6'd0, state_r};

endmodule

// File: tb/tb_fsm_responder.sv
// Scoreboard bench for fsm_responder: directed jobs push expected products and
// completion edges; a negedge monitor checks every done pulse and reset state.
module tb_fsm_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = 8'd0;
    logic [7:0]  b = 8'd0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [7:0]  state;

    typedef struct {
        logic [15:0] res;
        int          edge_at;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   edge_n   = 0;
    int   busy_run = 0;

    fsm_responder #(.WIDTH(8)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .state  (state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: reset values while reset is low, scoreboard pop on every done.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            check("rst_state", state, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_result", result, 0);
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 result=%0d, expected no pulse", result);
                end else begin
                    e = sb.pop_front();
                    check("done_result", result, e.res);
                    check("done_edge", edge_n, e.edge_at);
                    check("busy_cycles", busy_run, 8);
                    check("done_state", state, 2);
                    check("done_busy", busy, 0);
                end
                busy_run = 0;
            end
        end
    end

    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [15:0] prod);
        exp_t e;
        @(posedge clock);
        #1;
        a = x;
        b = y;
        start = 1'b1;
        e.res = prod;
        e.edge_at = edge_n + 9;
        sb.push_back(e);
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_done: got no done within 40 cycles, expected a pulse");
    endtask

    initial begin
        exp_t e;
        // 1: reset held 16 cycles, then first normal cycle
        repeat (16) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_state", state, 0);
        check("post_rst_result", result, 0);

        // 2: 3*5
        issue(8'd3, 8'd5, 16'd15);
        wait_done();
        @(posedge clock);
        #1;
        check("t2_idle_state", state, 0);
        check("t2_idle_done", done, 0);
        check("t2_hold_result", result, 15);

        // 3: max operands
        issue(8'd255, 8'd255, 16'd65025);
        wait_done();

        // 4: start during RUN is ignored
        issue(8'd4, 8'd4, 16'd16);
        a = 8'd9;
        b = 8'd9;
        start = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        start = 1'b0;
        wait_done();
        @(posedge clock);
        #1;
        check("t4_no_restart", state, 0);
        check("t4_result", result, 16);

        // 5: back-to-back job accepted in DONE
        issue(8'd2, 8'd3, 16'd6);
        wait_done();
        a = 8'd7;
        b = 8'd6;
        start = 1'b1;
        e.res = 16'd42;
        e.edge_at = edge_n + 9;
        sb.push_back(e);
        @(posedge clock);
        #1;
        start = 1'b0;
        check("t5_no_gap", state, 1);
        wait_done();
        @(posedge clock);
        #1;
        check("t5_result_hold", result, 42);

        // 6: reset mid-job abandons it
        issue(8'd10, 8'd10, 16'd100);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("t6_async_state", state, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_result", result, 0);
        sb.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (12) @(posedge clock);
        issue(8'd0, 8'd200, 16'd0);
        wait_done();

        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clock);
        check("sb_drained", sb.size(), 0);
        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
